// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 160x120 4bpp framebuffer scanout scaled 4x to 640x480 with a double-buffered 12-bit palette; define VGA_FB_INVERT_OUT_EN to invert colour/sync outputs
module vga_fb_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        i_HPos,
  input  logic [9:0]        i_VPos,
  input  logic              i_hSync,
  input  logic              i_vSync,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [3:0]        i_wr_data,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_idx,
  input  logic [11:0]       i_pal_rgb,
  output logic [3:0]        o_R,
  output logic [3:0]        o_G,
  output logic [3:0]        o_B,
  output logic              o_hSync,
  output logic              o_vSync,
  output logic              o_frame_start,
  output logic              o_wr_err
);
`ifdef VGA_FB_INVERT_OUT_EN
  localparam logic [13:0] INV = '1;
`else
  localparam logic [13:0] INV = '0;
`endif
  localparam int FB_N = FB_W * FB_H;
  logic [3:0] fb [FB_N];
  logic [11:0] sh_pal [16];
  logic [11:0] act_pal [16];
  logic [ADDR_W-1:0] v, h, addr, s1_addr;
  logic act, commit, wr, in_range;
  logic s1_act, s1_hs, s1_vs, s1_fs;
  logic s2_act, s2_hs, s2_vs, s2_fs;
  logic [3:0] s2_idx;
  logic [11:0] col;
  always_comb begin
    v = ADDR_W'(i_VPos >> SCALE_SHIFT);
    h = ADDR_W'(i_HPos >> SCALE_SHIFT);
    act = (i_HPos < 10'(H_ACTIVE)) && (i_VPos < 10'(V_ACTIVE));
    addr = act ? (v << 7) + (v << 5) + h : '0;
    commit = (i_HPos == '0) && (i_VPos == 10'(V_ACTIVE));
    wr = i_wr_valid && o_wr_ready;
    in_range = i_wr_addr < ADDR_W'(FB_N);
    col = s2_act ? act_pal[s2_idx] : '0;
  end
  always_ff @(posedge clk) begin
    if (wr && in_range) fb[i_wr_addr] <= i_wr_data;
    s2_idx <= fb[s1_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        sh_pal[i]  <= {3{4'(i)}};
        act_pal[i] <= {3{4'(i)}};
      end
    end else begin
      if (commit) act_pal <= sh_pal;
      if (i_pal_we) sh_pal[i_pal_idx] <= i_pal_rgb;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_act, s1_hs, s1_vs, s1_fs, s1_addr} <= '0;
      {s2_act, s2_hs, s2_vs, s2_fs} <= '0;
      {o_R, o_G, o_B, o_hSync, o_vSync} <= INV;
      o_frame_start <= 1'b0;
      o_wr_ready <= 1'b0;
      o_wr_err <= 1'b0;
    end else begin
      s1_act <= act;
      s1_addr <= addr;
      s1_hs <= i_hSync;
      s1_vs <= i_vSync;
      s1_fs <= (i_HPos == '0) && (i_VPos == '0);
      s2_act <= s1_act;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_fs <= s1_fs;
      {o_R, o_G, o_B, o_hSync, o_vSync} <= {col, s2_hs, s2_vs} ^ INV;
      o_frame_start <= s2_fs;
      o_wr_ready <= 1'b1;
      o_wr_err <= o_wr_err | (wr && !in_range);
    end
  end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: table and scoreboard bench for vga_fb_scanout
module tb_vga_fb_scanout;
`ifdef VGA_FB_INVERT_OUT_EN
  localparam logic [13:0] INV = '1;
`else
  localparam logic [13:0] INV = '0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] i_HPos = '0, i_VPos = '0;
  logic i_hSync = 1'b0, i_vSync = 1'b0;
  logic i_wr_valid = 1'b0;
  logic o_wr_ready;
  logic [14:0] i_wr_addr = '0;
  logic [3:0] i_wr_data = '0;
  logic i_pal_we = 1'b0;
  logic [3:0] i_pal_idx = '0;
  logic [11:0] i_pal_rgb = '0;
  logic [3:0] o_R, o_G, o_B;
  logic o_hSync, o_vSync, o_frame_start, o_wr_err;
  vga_fb_scanout dut (
    .clk(clk), .rst(rst), .i_HPos(i_HPos), .i_VPos(i_VPos),
    .i_hSync(i_hSync), .i_vSync(i_vSync), .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_pal_we(i_pal_we), .i_pal_idx(i_pal_idx), .i_pal_rgb(i_pal_rgb),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_hSync(o_hSync), .o_vSync(o_vSync),
    .o_frame_start(o_frame_start), .o_wr_err(o_wr_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [13:0] o; logic fs; string nm;} exp_t;
  typedef struct {logic [9:0] h; logic [9:0] v; logic hs; logic vs; logic [11:0] rgb; string nm;} vec_t;
  exp_t q[$];
  vec_t tbl[15];
  logic [3:0] fbm [19200];
  logic [11:0] shm [16];
  logic [11:0] actm [16];
  int tests = 0;
  int fails = 0;
  function automatic logic [11:0] model_px(input logic [9:0] h, input logic [9:0] v);
    return (h < 640 && v < 480) ? actm[fbm[int'(v / 4) * 160 + int'(h / 4)]] : 12'h000;
  endfunction
  task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic pal_reset();
    for (int i = 0; i < 16; i++) begin
      shm[i] = {3{4'(i)}};
      actm[i] = {3{4'(i)}};
    end
  endtask
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic hs, input logic vs,
                      input logic m, input logic [11:0] rgb, input string nm,
                      input logic wv = 1'b0, input logic [14:0] wa = '0, input logic [3:0] wd = '0,
                      input logic pw = 1'b0, input logic [3:0] pi = '0, input logic [11:0] pc = '0);
    exp_t e;
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk(e.nm, {o_R, o_G, o_B, o_hSync, o_vSync, o_frame_start}, {e.o, e.fs});
    end
    i_HPos = h; i_VPos = v; i_hSync = hs; i_vSync = vs;
    i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd;
    i_pal_we = pw; i_pal_idx = pi; i_pal_rgb = pc;
    if (wv && wa < 15'd19200) fbm[wa] = wd;
    e.o = {(m ? model_px(h, v) : rgb), hs, vs} ^ INV;
    e.fs = (h == 0) && (v == 0);
    e.nm = nm;
    q.push_back(e);
    if (h == 0 && v == 480) actm = shm;
    if (pw) shm[pi] = pc;
  endtask
  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "blank");
  endtask
  task automatic reset_dut();
    exp_t z;
    @(negedge clk);
    rst = 1'b1;
    i_HPos = 10'd700; i_VPos = 10'd500; i_hSync = 1'b0; i_vSync = 1'b0;
    i_wr_valid = 1'b0; i_pal_we = 1'b0;
    @(negedge clk);
    chk("rst_out", {o_R, o_G, o_B, o_hSync, o_vSync, o_frame_start}, {INV, 1'b0});
    chk("rst_wr_err", 15'(o_wr_err), 15'd0);
    chk("rst_wr_ready", 15'(o_wr_ready), 15'd0);
    rst = 1'b0;
    q.delete();
    z.o = INV; z.fs = 1'b0; z.nm = "post_rst_flush";
    q.push_back(z);
    q.push_back(z);
    z.nm = "post_rst_first";
    q.push_back(z);
    pal_reset();
  endtask
  initial begin
    tbl[0]  = '{10'd4,   10'd4,   1'b1, 1'b0, 12'hAAA, "px_4_4"};
    tbl[1]  = '{10'd7,   10'd7,   1'b0, 1'b1, 12'hAAA, "px_7_7"};
    tbl[2]  = '{10'd3,   10'd4,   1'b0, 1'b0, 12'h000, "px_3_4"};
    tbl[3]  = '{10'd8,   10'd4,   1'b1, 1'b1, 12'h000, "px_8_4"};
    tbl[4]  = '{10'd4,   10'd3,   1'b0, 1'b0, 12'h000, "px_4_3"};
    tbl[5]  = '{10'd4,   10'd8,   1'b1, 1'b0, 12'h000, "px_4_8"};
    tbl[6]  = '{10'd636, 10'd0,   1'b1, 1'b0, 12'h555, "px_636_0"};
    tbl[7]  = '{10'd639, 10'd0,   1'b0, 1'b1, 12'h555, "px_639_0"};
    tbl[8]  = '{10'd640, 10'd0,   1'b1, 1'b0, 12'h000, "px_640_0"};
    tbl[9]  = '{10'd0,   10'd479, 1'b0, 1'b0, 12'h777, "px_0_479"};
    tbl[10] = '{10'd4,   10'd480, 1'b1, 1'b1, 12'h000, "px_4_480"};
    tbl[11] = '{10'd0,   10'd0,   1'b1, 1'b1, 12'h000, "px_0_0"};
    tbl[12] = '{10'd1,   10'd0,   1'b0, 1'b0, 12'h000, "px_1_0"};
    tbl[13] = '{10'd799, 10'd524, 1'b1, 1'b1, 12'h000, "px_799_524"};
    tbl[14] = '{10'd5,   10'd5,   1'b0, 1'b0, 12'hAAA, "px_5_5"};
    reset_dut();
    blank(1);
    chk("wr_ready", 15'(o_wr_ready), 15'd1);
    for (int a = 0; a < 19200; a++)
      step(10'd700, 10'd500, 1'(a), 1'(a >> 1), 1'b1, 12'h0, "zero_blank", 1'b1, 15'(a), 4'h0);
    for (int v = 0; v < 525; v += 37)
      for (int h = 0; h < 800; h += 13)
        step(10'(h), 10'(v), (h >= 656 && h < 752), (v >= 490 && v < 492), 1'b1, 12'h0, "sweep");
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "wr_161", 1'b1, 15'd161, 4'hA);
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "wr_159", 1'b1, 15'd159, 4'h5);
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "wr_19040", 1'b1, 15'd19040, 4'h7);
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "wr_4010", 1'b1, 15'd4010, 4'h3);
    for (int i = 0; i < 15; i++) step(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, 1'b0, tbl[i].rgb, tbl[i].nm);
    step(10'd40, 10'd100, 1'b1, 1'b0, 1'b0, 12'h333, "pal_pre");
    step(10'd41, 10'd100, 1'b0, 1'b1, 1'b0, 12'h333, "pal_shadow_wr", 1'b0, '0, '0, 1'b1, 4'd3, 12'hF00);
    step(10'd43, 10'd103, 1'b1, 1'b1, 1'b0, 12'h333, "pal_hold_a");
    step(10'd40, 10'd101, 1'b0, 1'b0, 1'b0, 12'h333, "pal_hold_b");
    blank(3);
    step(10'd0, 10'd480, 1'b0, 1'b1, 1'b0, 12'h000, "pal_commit", 1'b0, '0, '0, 1'b1, 4'd5, 12'h0F0);
    blank(3);
    step(10'd40, 10'd100, 1'b1, 1'b0, 1'b0, 12'hF00, "pal_new");
    step(10'd636, 10'd0, 1'b0, 1'b0, 1'b0, 12'h555, "pal_commit_cycle_wr");
    blank(3);
    step(10'd0, 10'd480, 1'b0, 1'b0, 1'b0, 12'h000, "pal_commit2");
    blank(3);
    step(10'd639, 10'd0, 1'b0, 1'b1, 1'b0, 12'h0F0, "pal_next_commit");
    step(10'd4, 10'd4, 1'b1, 1'b0, 1'b0, 12'hAAA, "pal_other");
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "err_wr", 1'b1, 15'd19200, 4'h9);
    blank(1);
    chk("wr_err_set", 15'(o_wr_err), 15'd1);
    step(10'd4, 10'd4, 1'b0, 1'b0, 1'b0, 12'hAAA, "err_nochange_a");
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, "err_nochange_b");
    blank(3);
    chk("wr_err_sticky", 15'(o_wr_err), 15'd1);
    step(10'd700, 10'd500, 1'b0, 1'b0, 1'b1, 12'h0, "wr_8010", 1'b1, 15'd8010, 4'h3);
    for (int i = 0; i < 4; i++) step(10'd40, 10'd200, 1'b1, 1'b1, 1'b0, 12'hF00, "pre_rst");
    reset_dut();
    step(10'd40, 10'd200, 1'b1, 1'b0, 1'b0, 12'h333, "post_rst_px");
    step(10'd44, 10'd200, 1'b0, 1'b1, 1'b0, 12'h000, "post_rst_nb");
    step(10'd40, 10'd203, 1'b1, 1'b1, 1'b0, 12'h333, "post_rst_px2");
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, "post_rst_fs");
    blank(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Pixel stage directly downstream of the VGA timing generator.
- Consumes HPos/VPos/hSync/vSync and emits 4-bit R/G/B plus matching syncs for the VGA PMOD.
- Holds a 160x120, 4-bpp indexed framebuffer, scaled 4x to 640x480, and a 16-entry 12-bit palette.
- CPU-side write port fills the framebuffer; palette updates are double-buffered and committed at frame boundary.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- SCALE_SHIFT, 2, log2 of pixel replication factor.
- FB_W, 160, framebuffer width (H_ACTIVE>>SCALE_SHIFT).
- FB_H, 120, framebuffer height (V_ACTIVE>>SCALE_SHIFT).
- ADDR_W, 15, framebuffer address width.

Ports:
- clk  in  1  pixel clock, same clock as VGA timing generator.
- rst  in  1  synchronous reset, active-high.
- i_HPos  in  10  horizontal position from timing generator.
- i_VPos  in  10  vertical position from timing generator.
- i_hSync  in  1  hsync from timing generator.
- i_vSync  in  1  vsync from timing generator.
- i_wr_valid  in  1  framebuffer write request.
- o_wr_ready  out  1  write accepted this cycle when high with valid.
- i_wr_addr  in  ADDR_W  pixel address, y*FB_W+x.
- i_wr_data  in  4  palette index.
- i_pal_we  in  1  palette shadow write strobe.
- i_pal_idx  in  4  palette entry.
- i_pal_rgb  in  12  {R[3:0],G[3:0],B[3:0]}.
- o_R, o_G, o_B  out  4 each  pixel colour.
- o_hSync, o_vSync  out  1 each  syncs aligned to colour.
- o_frame_start  out  1  one-cycle pulse, aligned to output of pixel (0,0).
- o_wr_err  out  1  sticky out-of-range write flag.

Behaviour:
- Reset (synchronous, active-high): o_R/o_G/o_B=0, o_hSync=o_vSync=0, o_frame_start=0, o_wr_err=0, o_wr_ready=0. All pipeline stages cleared.
- Palette reset: shadow and active entry i = {i,i,i} (grayscale). Framebuffer contents are not reset.
- Pipeline: fixed 3-cycle latency from i_* timing inputs to all outputs.
  - S1: active = (HPos<H_ACTIVE)&&(VPos<V_ACTIVE). addr = (VPos>>2)*160 + (HPos>>2), computed as (v<<7)+(v<<5)+h, 15-bit, no overflow for active pixels.
  - S2: BRAM read of index.
  - S3: active palette lookup, output register.
  - When not active, S3 outputs colour 0.
  - Syncs and frame-start flag travel the same 3 stages; o_frame_start is asserted when the S3 pixel is HPos==0, VPos==0.
- Write port:
  - o_wr_ready=1 every cycle after reset.
  - A write occurs when i_wr_valid&&o_wr_ready.
  - addr<FB_W*FB_H (19200): index written, visible on the next scanout read of that address; read-during-write to the same address returns the old data.
  - addr>=19200: write dropped, o_wr_err set; it stays set until rst.
- Palette:
  - i_pal_we writes the shadow entry only.
  - Shadow is copied to active (all 16 entries) in the single cycle where S1 sees HPos==0 and VPos==V_ACTIVE (first blanking line).
  - A shadow write in that same cycle lands in shadow; it is committed at the next frame.
  - Active palette never changes mid-frame.
- Simultaneous events: framebuffer write, palette write and scanout are independent in the same cycle.
- Reset mid-frame: outputs go to 0 on the next edge. Scanout resumes correctly with the new inputs after 3 cycles.

Optional Feature:
- Macro VGA_FB_INVERT_OUT_EN.
- Defined: o_R/o_G/o_B/o_hSync/o_vSync are bitwise inverted at the output register. The reset value of these outputs becomes all-ones, as the board's inverting PMOD requires.
- Undefined: true polarity; reset values are as in Behaviour.
- Internal logic, latency and o_frame_start/o_wr_err are identical in both builds.

Test Plan:
- Reset, then drive HPos/VPos sweep with default palette and framebuffer zeroed by writes -> all active pixels RGB=000. Syncs equal inputs delayed exactly 3 cycles.
- Write addr 161 (x=1,y=1) data 4'hA -> pixels HPos 4..7 on VPos 4..7 output {A,A,A}; neighbours output 0.
- Write shadow entry 3 = 12'hF00 mid-frame (VPos=100), with pixel index 3 on screen:
  - Rest of that frame still outputs 333.
  - After the VPos=480 commit, the next frame outputs F00.
- Write addr 19200 -> no framebuffer change, o_wr_err=1 persists. Assert rst -> o_wr_err=0.
- Pixel at HPos=639 is active; HPos=640 and VPos=480 output 0 regardless of framebuffer content. o_frame_start is a single pulse 3 cycles after (0,0).
- Assert rst for 1 cycle at VPos=200 -> outputs 0 next cycle; from 3 cycles after release, colour and syncs track inputs again.
- Build with VGA_FB_INVERT_OUT_EN -> reset outputs all ones, and entry F00 appears as R=0,G=F,B=F.
